// File: rtl/result_drain.sv
// result_drain: collects result rows from the systolic array, which shift out
// bottom row first. It keeps only the active rows and columns, then streams
// the rows to the host in natural order over a valid/ready handshake.
module result_drain #(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4,
    parameter int LAT           = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 rows_used,
    input  logic [7:0]                 cols_used,
    output logic                       through,
    input  logic [7:0]                 down_out [0:COLUMN_NUMBER-1],
    output logic [8*COLUMN_NUMBER-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = $clog2(LAT + ROW_NUMBER + 1);
    localparam int IW = $clog2(ROW_NUMBER + 1);
    localparam int KW = $clog2(COLUMN_NUMBER + 1);
    localparam int DW = 8 * COLUMN_NUMBER;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rows_eff_q, rows_eff_d;
    logic [KW-1:0]   cols_eff_q, cols_eff_d;
    logic            done_q, done_d;
    logic [DW-1:0]   buf_q [ROW_NUMBER];

    logic            cap_en;
    int              cap_row;
    logic [DW-1:0]   cap_data;

    // Control state; outputs are decoded from state so reset drops them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rows_eff_q <= '0;
            cols_eff_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rows_eff_q <= rows_eff_d;
            cols_eff_q <= cols_eff_d;
            done_q     <= done_d;
        end
    end

    // Next-state: latch clamped sizes on start, count the drain window, step rows on handshakes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rows_eff_d = rows_eff_q;
        cols_eff_d = cols_eff_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_eff_d = (rows_used > 8'(ROW_NUMBER))    ? IW'(ROW_NUMBER)    : IW'(rows_used);
                    cols_eff_d = (cols_used > 8'(COLUMN_NUMBER)) ? KW'(COLUMN_NUMBER) : KW'(cols_used);
                    if (rows_used == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(LAT + ROW_NUMBER - 1)) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (out_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture decode: map the drain count to an array row and blank unused columns.
    always_comb begin
        cap_en   = 1'b0;
        cap_row  = 0;
        cap_data = '0;
        if (state_q == S_DRAIN && int'(cnt_q) >= LAT) begin
            cap_row = ROW_NUMBER - 1 - (int'(cnt_q) - LAT);
            cap_en  = cap_row < int'(rows_eff_q);
        end
        for (int c = 0; c < COLUMN_NUMBER; c++) begin
            cap_data[8*c +: 8] = (c < int'(cols_eff_q)) ? down_out[c] : 8'h00;
        end
    end

    // Row buffer; contents only matter after a full drain, so it is never reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROW_NUMBER; r++) begin
            if (cap_en && cap_row == r) buf_q[r] <= cap_data;
        end
    end

    // Output decode: everything is zero outside SEND except the done pulse.
    always_comb begin
        through   = (state_q == S_DRAIN);
        out_valid = (state_q == S_SEND);
        busy      = (state_q != S_IDLE);
        done      = done_q;
        out_last  = (state_q == S_SEND) && (idx_q == rows_eff_q - 1'b1);
        out_data  = '0;
        if (state_q == S_SEND) begin
            for (int r = 0; r < ROW_NUMBER; r++) begin
                if (int'(idx_q) == r) out_data = buf_q[r];
            end
        end
    end

endmodule

// File: doc/result_drain.md
# result_drain

Output-side controller for the systolic `array`. After a matrix product has accumulated, it asserts `through` and captures the rows that shift out of `down_out`, bottom row first. It discards rows beyond the active matrix height and buffers the rest. It then streams the result rows to the host in natural order (row 0 first) over a valid/ready interface. It sits between the array's `down_out`/`through` pins and the TPU's result sink, replacing ad-hoc collection in the top level.

## Interface
- `ROW_NUMBER`, 4, array rows; also the buffer depth.
- `COLUMN_NUMBER`, 4, array columns; also the row width in bytes.
- `LAT`, 1, cycles from `through` rising to the first valid row on `down_out`. Legal range 0–3.
- `clk` input 1: clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state and outputs immediately.
- `start` input 1: pulse that begins a drain. Sampled only in IDLE.
- `rows_used` input 8: valid result rows (size_row_A). Latched on `start`.
- `cols_used` input 8: valid result columns (size_column_B). Latched on `start`.
- `through` output 1: drives the array's `through` pin.
- `down_out` input 8 × [0:COLUMN_NUMBER-1]: array column outputs.
- `out_data` output 8·COLUMN_NUMBER: one result row. Column c occupies bits [8c+7:8c].
- `out_valid` output 1: `out_data` holds a valid row.
- `out_ready` input 1: sink accepts the row.
- `out_last` output 1: the current beat is the final row.
- `busy` output 1: high in DRAIN and SEND.
- `done` output 1: single-cycle pulse when the job completes.

## Operation
- States: IDLE, DRAIN, SEND. Reset enters IDLE. All outputs are 0 in reset and in IDLE, except `done`, which pulses as described below.
- Clamping on latch:
  - `rows_eff` = min(`rows_used`, ROW_NUMBER).
  - `cols_eff` = min(`cols_used`, COLUMN_NUMBER).
- IDLE transitions on `start`:
  - If `rows_eff`=0: stay in IDLE and pulse `done` on the next cycle. No `through`, no output beats.
  - Otherwise: go to DRAIN with `cnt`=0.
- DRAIN lasts exactly LAT+ROW_NUMBER cycles, with `through`=1 throughout.
  - At each edge, if `cnt` ≥ LAT, the block captures `down_out`.
  - The captured data is array row r = ROW_NUMBER-1-(`cnt`-LAT).
  - The row is stored in buffer[r] only if r < `rows_eff`. Rows r ≥ `rows_eff` are dropped.
  - Bytes of columns c ≥ `cols_eff` are stored as 0.
  - `cnt` increments every cycle. At the last count, go to SEND with `idx`=0.
- SEND:
  - `through`=0, `out_valid`=1.
  - `out_data` = buffer[`idx`].
  - `out_last` = (`idx` == `rows_eff`-1).
  - On `out_valid`&&`out_ready`: `idx`++. If that beat was the last, go to IDLE and pulse `done` in the following cycle.
- AXI-stream-like rules:
  - `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops before its handshake.
- `start` is ignored in DRAIN and SEND. `start` in the same cycle as the final handshake is also ignored.
- Async `reset` mid-DRAIN or mid-SEND: state returns to IDLE immediately and `through`/`out_valid` fall without a clock. Buffer contents are not cleared (don't-care).
- Widths: `cnt` is $clog2(LAT+ROW_NUMBER+1) bits; `idx` is $clog2(ROW_NUMBER+1) bits. No arithmetic on data.

## Timing
- Edge E0 samples `start`. `through`=1 from E0 to E0+LAT+ROW_NUMBER (exclusive), i.e. LAT+ROW_NUMBER cycles.
- The first `out_valid` appears in the cycle after DRAIN ends, which is LAT+ROW_NUMBER cycles after E0.
- With `out_ready` held at 1, one row is transferred per cycle. Total job time from `start` to `done` = LAT+ROW_NUMBER+`rows_eff`+1 cycles.
- `busy` rises at E0 and falls on the edge where the last handshake completes. `done` is high in the cycle immediately after `busy` falls.
- Back-to-back: a new `start` is accepted in the `done` cycle.

## Test plan
- Basic 2×1 product (ROW_NUMBER=COLUMN_NUMBER=4, LAT=1):
  - Stimulus: rows_used=2, cols_used=1, `out_ready`=1. After `through` rises, `down_out` shows, in order: junk {AA,AA,AA,AA}; row3 {55,..}; row2 {66,..}; row1 {7A,11,22,33}; row0 {32,44,55,66}.
  - Required response: beat0 `out_data`=0x00000032, `out_last`=0; beat1 `out_data`=0x0000007A, `out_last`=1; `done` 8 cycles after `start`.
- Full 4×4, all columns:
  - Stimulus: rows_used=4, cols_used=4, rows 3..0 presented as 0x03030303, 0x02020202, 0x01010101, 0x00000000.
  - Required response: 4 beats with values 0x00000000, 0x01010101, 0x02020202, 0x03030303; `out_last` only on beat 3.
- Backpressure:
  - Stimulus: basic case with `out_ready` toggling 0,0,1,0,1.
  - Required response: `out_data` stable while stalled; exactly 2 beats; no duplicated or skipped rows.
- Clamp and zero:
  - Stimulus: rows_used=9, cols_used=6.
  - Required response: 4 beats, all bytes kept.
  - Stimulus: rows_used=0.
  - Required response: no `through`, `done` one cycle after `start`, `busy` never high.
- Async reset mid-SEND:
  - Stimulus: assert `reset` between clock edges after beat0.
  - Required response: `out_valid`, `through`, `busy` go to 0 without a clock edge. A following job produces correct output.
- Start while busy:
  - Stimulus: pulse `start` during DRAIN with rows_used=1.
  - Required response: ignored; original job output unchanged.
